spi_slave_core: RTL and testbench

Parametrised SPI slave that replaces the single-mode, sck-clocked slave with a design running entirely in the system clock domain. It synchronises sck, cs_n and mosi, supports all four CPOL/CPHA modes and a configurable word width and bit order, and carries back-to-back words within one chip-select frame. It sits between the external SPI pins and the on-chip register/FIFO logic, which it talks to through a one-entry transmit holding register and a pulsed receive strobe.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync.sv | 21 ++
 rtl/spi_slave_core.sv | 116 +++++++++++
 tb/tb_spi_slave_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the system-clock SPI slave.
package spi_pkg;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_e;

   // {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic int cnt_w(input int data_w);
      return (data_w <= 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser for an asynchronous single-bit input with a selectable reset level.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= {SYNC_STAGES{RST_VAL}};
      else        ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave running in the clk domain: oversampled sck/cs_n/mosi, all four modes,
// back-to-back words per frame, one-entry transmit holding register.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun,
   output logic              frame_abort,
   output logic              busy
);

   localparam int            CW       = cnt_w(DATA_W);
   localparam logic [CW-1:0] LAST     = CW'(DATA_W - 1);
   localparam logic          IDLE_SCK = (CPOL != 0);

   logic              sck_s, cs_s, mosi_s, sck_q, cs_q;
   spi_state_e        state;
   logic [CW-1:0]     bit_cnt, cnt_nxt;
   logic [DATA_W-1:0] hold, tx_shift, rx_shift, rx_nxt, tx_word, tx_rest;
   logic              hold_full, accept, fetch, active, lead, trail, cs_fall, cs_rise;
   logic              sample_e, shift_e, sample_done, tx_bit;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_SCK)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

   assign active  = (state == ACTIVE);
   assign lead    = (sck_s != sck_q) && (sck_q == IDLE_SCK);
   assign trail   = (sck_s != sck_q) && (sck_s == IDLE_SCK);
   assign cs_fall = cs_q && !cs_s;
   assign cs_rise = !cs_q && cs_s;

   // A closing frame still completes a pending sample but never shifts out more data.
   assign sample_e    = active && ((CPHA != 0) ? trail : lead);
   assign shift_e     = active && !cs_rise && ((CPHA != 0) ? lead : trail);
   assign sample_done = sample_e && (bit_cnt == LAST);
   assign cnt_nxt     = !sample_e ? bit_cnt : (sample_done ? '0 : bit_cnt + CW'(1));

   // CPHA=0 must present the first bit before the first sck edge, so it fetches on cs_n fall.
   assign fetch  = (!active && cs_fall && (CPHA == 0)) || (shift_e && (bit_cnt == '0));
   assign accept = tx_valid && !hold_full;

   assign tx_word = fetch ? (hold_full ? hold : '0) : tx_shift;
   assign tx_bit  = (MSB_FIRST != 0) ? tx_word[DATA_W-1] : tx_word[0];
   assign tx_rest = (MSB_FIRST != 0) ? {tx_word[DATA_W-2:0], 1'b0} : {1'b0, tx_word[DATA_W-1:1]};
   assign rx_nxt  = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q       <= IDLE_SCK;
         cs_q        <= 1'b1;
         state       <= IDLE;
         bit_cnt     <= '0;
         hold        <= '0;
         hold_full   <= 1'b0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         underrun    <= 1'b0;
         frame_abort <= 1'b0;
         miso        <= 1'b0;
      end else begin
         sck_q       <= sck_s;
         cs_q        <= cs_s;
         rx_valid    <= sample_done;
         underrun    <= fetch && !hold_full;
         frame_abort <= active && cs_rise && (cnt_nxt != '0);
         if (fetch)       hold_full <= accept;
         else if (accept) hold_full <= 1'b1;
         if (accept)      hold      <= tx_data;
         if (sample_e)    rx_shift  <= rx_nxt;
         if (sample_done) rx_data   <= rx_nxt;
         if (fetch || shift_e) begin
            miso     <= tx_bit;
            tx_shift <= tx_rest;
         end
         if (!active) begin
            if (cs_fall) begin
               state   <= ACTIVE;
               bit_cnt <= '0;
            end
         end else if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
         end else begin
            bit_cnt <= cnt_nxt;
         end
      end
   end

   assign tx_ready = !hold_full;
   assign miso_oe  = active;
   assign busy     = active;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: five slaves (modes 0..3 MSB-first, mode 0 LSB-first) share one SPI master.
module tb_spi_slave_core;

   localparam int N = 5;
   localparam int H = 8;
   localparam logic [N-1:0] CPHA_V = 5'b01010;
   localparam logic [N-1:0] MSB_V  = 5'b01111;

   logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic [7:0]   tx_data  = '0;
   logic [N-1:0] tx_valid = '0;
   logic [N-1:0] miso, miso_oe, tx_ready, rx_valid, underrun, frame_abort, busy;
   logic [7:0]   rx_data [N];
   logic [7:0]   mcap [N];
   int rxc [N], unc [N], abc [N];
   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam logic PL = (g == 2 || g == 3);
      spi_slave_core #(
         .DATA_W(8), .CPOL(int'(PL)), .CPHA(int'(CPHA_V[g])),
         .MSB_FIRST(int'(MSB_V[g])), .SYNC_STAGES(2)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .sck(sclk ^ PL), .cs_n(cs_n), .mosi(mosi),
         .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data), .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
         .underrun(underrun[g]), .frame_abort(frame_abort[g]), .busy(busy[g]));
   end

   always @(posedge clk)
      for (int g = 0; g < N; g++) begin
         if (rx_valid[g])    rxc[g]++;
         if (underrun[g])    unc[g]++;
         if (frame_abort[g]) abc[g]++;
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Master samples miso just before the edge each slave's mode drives it to be sampled on.
   task automatic cap(input logic ph);
      for (int g = 0; g < N; g++)
         if (CPHA_V[g] == ph)
            mcap[g] = MSB_V[g] ? {mcap[g][6:0], miso[g]} : {miso[g], mcap[g][7:1]};
   endtask

   task automatic load(input logic [N-1:0] mask, input logic [7:0] v);
      tx_data  = v;
      tx_valid = mask;
      cyc(1);
      tx_valid = '0;
   endtask

   task automatic push(input int g, input logic [7:0] v, input string tag);
      logic [N-1:0] m;
      int t;
      t = 0;
      while (!tx_ready[g] && t < 64) begin
         cyc(1);
         t++;
      end
      chk(tag, 32'(tx_ready[g]), 32'd1);
      m    = '0;
      m[g] = 1'b1;
      load(m, v);
   endtask

   task automatic xbit(input logic b);
      mosi = b;
      cyc(H);
      cap(1'b0);
      sclk = 1'b1;
      cyc(H);
      cap(1'b1);
      sclk = 1'b0;
      cyc(2);
   endtask

   task automatic xword(input logic [7:0] v, input int pg, input logic [7:0] pv, input string ptag);
      for (int g = 0; g < N; g++) mcap[g] = '0;
      for (int i = 7; i >= 0; i--) begin
         xbit(v[i]);
         if (i == 6 && pg >= 0) push(pg, pv, ptag);
      end
   endtask

   task automatic cs_lo;
      cs_n = 1'b0;
      cyc(H);
   endtask

   task automatic cs_hi;
      cyc(H);
      cs_n = 1'b1;
      cyc(H);
   endtask

   initial begin
      int rx0 [N], un0 [N], ab0 [N];
      cyc(3);
      chk("rst_miso",    32'(miso[0]), 32'd0);
      chk("rst_oe",      32'(miso_oe[0]), 32'd0);
      chk("rst_txrdy",   32'(tx_ready), 32'h1f);
      chk("rst_rxdata",  32'(rx_data[0]), 32'd0);
      chk("rst_rxvalid", 32'(rx_valid), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_abort",   32'(frame_abort), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      rst_n = 1'b1;
      cyc(4);

      // single word, all modes
      load('1, 8'hA5);
      rx0 = rxc; un0 = unc;
      cs_lo;
      chk("f1_busy", 32'(busy[0]), 32'd1);
      chk("f1_oe",   32'(miso_oe[0]), 32'd1);
      xword(8'h3C, -1, 8'h00, "");
      cs_hi;
      for (int g = 0; g < N; g++) begin
         chk($sformatf("f1_rx%0d", g),   32'(rx_data[g]), 32'h3C);
         chk($sformatf("f1_nrx%0d", g),  32'(rxc[g] - rx0[g]), 32'd1);
         chk($sformatf("f1_miso%0d", g), 32'(mcap[g]), 32'hA5);
         chk($sformatf("f1_und%0d", g),  32'(unc[g] - un0[g]), CPHA_V[g] ? 32'd0 : 32'd1);
         chk($sformatf("f1_idle%0d", g), 32'(busy[g]), 32'd0);
      end

      // LSB-first slave receives 0x01 when the MSB-first ones see 0x80
      load('1, 8'h69);
      cs_lo;
      xword(8'h80, -1, 8'h00, "");
      cs_hi;
      for (int g = 0; g < N; g++) begin
         chk($sformatf("f2_rx%0d", g),   32'(rx_data[g]), (g == 4) ? 32'h01 : 32'h80);
         chk($sformatf("f2_miso%0d", g), 32'(mcap[g]), 32'h69);
      end
      chk("f2_lsb_first_bit", 32'(mcap[4][0]), 32'd1);

      // three-word burst on mode 0 with handshake refills
      load(5'b00001, 8'h11);
      rx0 = rxc; un0 = unc;
      cs_lo;
      xword(8'hC3, 0, 8'h22, "push22");
      chk("b1_miso", 32'(mcap[0]), 32'h11);
      chk("b1_rx",   32'(rx_data[0]), 32'hC3);
      xword(8'h5A, 0, 8'h33, "push33");
      chk("b2_miso", 32'(mcap[0]), 32'h22);
      chk("b2_rx",   32'(rx_data[0]), 32'h5A);
      xword(8'h0F, 0, 8'h44, "push44");
      chk("b3_miso", 32'(mcap[0]), 32'h33);
      chk("b3_rx",   32'(rx_data[0]), 32'h0F);
      cs_hi;
      chk("b_nrx",  32'(rxc[0] - rx0[0]), 32'd3);
      chk("b_nund", 32'(unc[0] - un0[0]), 32'd0);
      chk("b_txrdy", 32'(tx_ready[0]), 32'd1);

      // empty holding register at the second word of a mode 1 frame
      load(5'b00010, 8'hF0);
      un0 = unc;
      cs_lo;
      xword(8'h00, -1, 8'h00, "");
      chk("u1_miso", 32'(mcap[1]), 32'hF0);
      xword(8'h00, -1, 8'h00, "");
      chk("u2_miso", 32'(mcap[1]), 32'h00);
      cs_hi;
      chk("u_nund", 32'(unc[1] - un0[1]), 32'd1);

      // cs_n rises after five bits, then a clean frame
      rx0 = rxc; ab0 = abc;
      cs_lo;
      for (int i = 0; i < 5; i++) xbit(1'b1);
      cs_hi;
      chk("a_nabort", 32'(abc[0] - ab0[0]), 32'd1);
      chk("a_nrx",    32'(rxc[0] - rx0[0]), 32'd0);
      chk("a_busy",   32'(busy[0]), 32'd0);
      rx0 = rxc;
      cs_lo;
      xword(8'h96, -1, 8'h00, "");
      cs_hi;
      chk("a2_rx",  32'(rx_data[0]), 32'h96);
      chk("a2_nrx", 32'(rxc[0] - rx0[0]), 32'd1);

      // reset mid-word with the holding register full
      load(5'b00001, 8'h77);
      cs_lo;
      push(0, 8'h55, "push55");
      chk("r_full", 32'(tx_ready[0]), 32'd0);
      for (int i = 0; i < 3; i++) xbit(1'b1);
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      cyc(2);
      chk("r_miso",    32'(miso[0]), 32'd0);
      chk("r_oe",      32'(miso_oe), 32'd0);
      chk("r_txrdy",   32'(tx_ready), 32'h1f);
      chk("r_rxdata",  32'(rx_data[0]), 32'd0);
      chk("r_rxvalid", 32'(rx_valid), 32'd0);
      chk("r_und",     32'(underrun), 32'd0);
      chk("r_abort",   32'(frame_abort), 32'd0);
      chk("r_busy",    32'(busy), 32'd0);
      rst_n = 1'b1;
      cyc(4);
      chk("r_post_busy",  32'(busy), 32'd0);
      chk("r_post_txrdy", 32'(tx_ready), 32'h1f);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
